// File: rtl/aes_ctrl_pkg.sv
// Shared constants for the Avalon AES decryption controller: register map and run-state encoding.
package aes_ctrl_pkg;

  localparam int NUM_WORDS     = 16;
  localparam int ADDR_MSG_DEC0 = 8;
  localparam int ADDR_CYCLES   = 12;
  localparam int ADDR_STATUS   = 13;
  localparam int ADDR_START    = 14;

  // Encoding is software-visible through the STATUS register.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/aes_reg_word.sv
// 32-bit register word with per-byte write enables, a load enable and a synchronous clear.
module aes_reg_word (
  input  logic        clk,
  input  logic        srst,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  be,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] q_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      q_reg <= '0;
    end else if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) q_reg[8*i +: 8] <= d[8*i +: 8];
      end
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/avalon_aes_ctrl.sv
// Avalon-MM register file and run controller in front of the AES decryption core:
// holds key/ciphertext, sequences one decryption per START level, captures plaintext and run latency.
module avalon_aes_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic         AES_START,
  input  logic         AES_DONE,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic [127:0] AES_MSG_DEC,
  output logic [31:0]  EXPORT_DATA
);

  logic [31:0]      word_q [NUM_WORDS];
  logic [31:0]      rdata_reg;
  ctrl_state_t      state_reg;
  ctrl_state_t      state_next;
  logic             bus_wr;
  logic             start_wr;
  logic             start_level;
  logic             start_go;
  logic             capture;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] cyc_inc;

  assign bus_wr   = AVL_CS && AVL_WRITE;
  assign start_wr = bus_wr && (AVL_ADDR == 4'(ADDR_START)) && AVL_BYTE_EN[0];

  // The FSM sees a START write in the same cycle it lands, so the run begins one cycle after the write.
  assign start_level = start_wr ? AVL_WRITEDATA[0] : word_q[ADDR_START][0];
  assign start_go    = (state_reg == IDLE) && start_level;
  assign capture     = (state_reg == RUN) && AES_DONE;

  assign cyc_cnt = word_q[ADDR_CYCLES][CNT_W-1:0];
  assign cyc_inc = (&cyc_cnt) ? cyc_cnt : cyc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_level) state_next = RUN;
      RUN:     if (AES_DONE)    state_next = HOLD;
      HOLD:    if (!start_level) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      logic        w_en;
      logic        w_clr;
      logic [3:0]  w_be;
      logic [31:0] w_d;

      if (gi < ADDR_MSG_DEC0) begin : g_operand
        // Key and ciphertext are frozen while the core is consuming them.
        assign w_en  = bus_wr && (AVL_ADDR == 4'(gi)) && (state_reg != RUN);
        assign w_clr = 1'b0;
        assign w_be  = AVL_BYTE_EN;
        assign w_d   = AVL_WRITEDATA;
      end else if (gi < ADDR_CYCLES) begin : g_result
        assign w_en  = capture;
        assign w_clr = 1'b0;
        assign w_be  = 4'hf;
        assign w_d   = AES_MSG_DEC[32*(11-gi) +: 32];
      end else if (gi == ADDR_CYCLES) begin : g_cycles
        assign w_en  = (state_reg == RUN);
        assign w_clr = start_go;
        assign w_be  = 4'hf;
        assign w_d   = 32'(cyc_inc);
      end else if (gi == ADDR_STATUS) begin : g_status
        assign w_en  = 1'b1;
        assign w_clr = 1'b0;
        assign w_be  = 4'hf;
        assign w_d   = {30'd0, state_next};
      end else if (gi == ADDR_START) begin : g_start
        assign w_en  = bus_wr && (AVL_ADDR == 4'(ADDR_START));
        assign w_clr = 1'b0;
        assign w_be  = AVL_BYTE_EN;
        assign w_d   = {31'd0, AVL_WRITEDATA[0]};
      end else begin : g_done
        assign w_en  = capture;
        assign w_clr = start_go;
        assign w_be  = 4'hf;
        assign w_d   = 32'd1;
      end

      aes_reg_word u_word (
        .clk  (CLK),
        .srst (RESET),
        .clr  (w_clr),
        .en   (w_en),
        .be   (w_be),
        .d    (w_d),
        .q    (word_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET)                rdata_reg <= '0;
    else if (AVL_CS && AVL_READ) rdata_reg <= word_q[AVL_ADDR];
  end

  assign AVL_READDATA = rdata_reg;
  assign AES_START    = (state_reg == RUN);
  assign AES_KEY      = {word_q[0], word_q[1], word_q[2], word_q[3]};
  assign AES_MSG_ENC  = {word_q[4], word_q[5], word_q[6], word_q[7]};
  assign EXPORT_DATA  = {word_q[4][31:16], word_q[7][15:0]};

endmodule

// File: tb/tb_avalon_aes_ctrl.sv
// Directed bench for avalon_aes_ctrl with an AES core stub and a register-level reference model.
module tb_avalon_aes_ctrl;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         AVL_CS = 1'b0;
  logic         AVL_READ = 1'b0;
  logic         AVL_WRITE = 1'b0;
  logic [3:0]   AVL_ADDR = 4'd0;
  logic [3:0]   AVL_BYTE_EN = 4'd0;
  logic [31:0]  AVL_WRITEDATA = 32'd0;
  logic [31:0]  AVL_READDATA;
  logic         AES_START;
  logic         AES_DONE;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_ENC;
  logic [127:0] AES_MSG_DEC;
  logic [31:0]  EXPORT_DATA;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  avalon_aes_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .AES_START(AES_START), .AES_DONE(AES_DONE),
    .AES_KEY(AES_KEY), .AES_MSG_ENC(AES_MSG_ENC), .AES_MSG_DEC(AES_MSG_DEC),
    .EXPORT_DATA(EXPORT_DATA)
  );

  always #5 CLK = ~CLK;

  // Core stub: once AES_START is seen it pulses DONE 5 cycles later, even if START is withdrawn.
  logic stub_active = 1'b0;
  int   stub_cnt = 0;
  always @(posedge CLK) begin
    if (AES_START && !stub_active) begin
      stub_active <= 1'b1;
      stub_cnt    <= 1;
    end else if (stub_active) begin
      if (stub_cnt == 5) stub_active <= 1'b0;
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign AES_DONE    = stub_active && (stub_cnt == 5);
  assign AES_MSG_DEC = {4{32'hece298dc}};

  // Reference model: register contents, run phase (0 idle, 1 running, 2 holding) and read port.
  logic [31:0] m_regs [16];
  logic [1:0]  m_state;
  logic [31:0] m_rdata;
  wire         m_wr   = AVL_CS && AVL_WRITE;
  wire [31:0]  m_mask = {{8{AVL_BYTE_EN[3]}}, {8{AVL_BYTE_EN[2]}}, {8{AVL_BYTE_EN[1]}}, {8{AVL_BYTE_EN[0]}}};
  wire         m_go   = (m_wr && AVL_ADDR == 4'd14 && AVL_BYTE_EN[0]) ? AVL_WRITEDATA[0] : m_regs[14][0];

  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) m_regs[i] <= 32'd0;
      m_state <= 2'd0;
      m_rdata <= 32'd0;
    end else begin
      if (AVL_CS && AVL_READ)
        m_rdata <= (AVL_ADDR == 4'd13) ? {30'd0, m_state} : m_regs[AVL_ADDR];
      if (m_wr && AVL_ADDR < 4'd8 && m_state != 2'd1)
        m_regs[AVL_ADDR] <= (m_regs[AVL_ADDR] & ~m_mask) | (AVL_WRITEDATA & m_mask);
      if (m_wr && AVL_ADDR == 4'd14 && AVL_BYTE_EN[0])
        m_regs[14] <= {31'd0, AVL_WRITEDATA[0]};
      if (m_state == 2'd0 && m_go) begin
        m_state    <= 2'd1;
        m_regs[12] <= 32'd0;
        m_regs[15] <= 32'd0;
      end else if (m_state == 2'd1) begin
        m_regs[12] <= (m_regs[12] == 32'hffffffff) ? m_regs[12] : m_regs[12] + 32'd1;
        if (AES_DONE) begin
          m_regs[8]  <= AES_MSG_DEC[127:96];
          m_regs[9]  <= AES_MSG_DEC[95:64];
          m_regs[10] <= AES_MSG_DEC[63:32];
          m_regs[11] <= AES_MSG_DEC[31:0];
          m_regs[15] <= 32'd1;
          m_state    <= 2'd2;
        end
      end else if (m_state == 2'd2 && !m_go) begin
        m_state <= 2'd0;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("mdl_readdata", {96'd0, AVL_READDATA}, {96'd0, m_rdata});
      check("mdl_aes_start", {127'd0, AES_START}, {127'd0, (m_state == 2'd1)});
      check("mdl_aes_key", AES_KEY, {m_regs[0], m_regs[1], m_regs[2], m_regs[3]});
      check("mdl_msg_enc", AES_MSG_ENC, {m_regs[4], m_regs[5], m_regs[6], m_regs[7]});
      check("mdl_export", {96'd0, EXPORT_DATA}, {96'd0, m_regs[4][31:16], m_regs[7][15:0]});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    tick();
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    $display("WR addr=%0d data=%h be=%b", a, d, be);
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    tick();
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    $display("RD addr=%0d data=%h", a, AVL_READDATA);
    check(name, {96'd0, AVL_READDATA}, {96'd0, exp});
  endtask

  task automatic wait_run_end(input string name);
    for (int i = 0; i < 50 && AES_START; i++) tick();
    check(name, {127'd0, AES_START}, 128'd0);
  endtask

  initial begin
    repeat (3) tick();
    RESET = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("reset_aes_start", {127'd0, AES_START}, 128'd0);
    for (int i = 0; i < 16; i++) rd_check("reset_read", 4'(i), 32'd0);

    // Operand load
    bus_write(4'd0, 32'h00010203, 4'hf);
    bus_write(4'd1, 32'h04050607, 4'hf);
    bus_write(4'd2, 32'h08090a0b, 4'hf);
    bus_write(4'd3, 32'h0c0d0e0f, 4'hf);
    bus_write(4'd4, 32'hdaec3055, 4'hf);
    bus_write(4'd5, 32'hdf058e1c, 4'hf);
    bus_write(4'd6, 32'h39e814ea, 4'hf);
    bus_write(4'd7, 32'h76f6747e, 4'hf);
    check("key_out", AES_KEY, 128'h000102030405060708090a0b0c0d0e0f);
    check("msg_enc_out", AES_MSG_ENC, 128'hdaec3055df058e1c39e814ea76f6747e);
    check("export_data", {96'd0, EXPORT_DATA}, {96'd0, 32'hdaec747e});

    // First run
    bus_write(4'd14, 32'd1, 4'hf);
    check("run1_start_next_cycle", {127'd0, AES_START}, {127'd0, 1'b1});
    wait_run_end("run1_done_in_time");
    for (int i = 8; i < 12; i++) rd_check("run1_msg_dec", 4'(i), 32'hece298dc);
    rd_check("run1_done_flag", 4'd15, 32'd1);
    rd_check("run1_cycles", 4'd12, 32'd6);
    rd_check("run1_status_hold", 4'd13, 32'd2);

    // START still 1 in HOLD: no second run
    repeat (10) tick();
    check("hold_no_rerun", {127'd0, AES_START}, 128'd0);
    rd_check("hold_status", 4'd13, 32'd2);
    bus_write(4'd14, 32'd0, 4'hf);
    rd_check("idle_after_clear", 4'd13, 32'd0);
    rd_check("done_kept_in_idle", 4'd15, 32'd1);

    // Second run: frozen operands, DONE cleared, same-cycle capture read
    bus_write(4'd14, 32'd1, 4'hf);
    bus_write(4'd0, 32'hffffffff, 4'hf);
    tick();
    tick();
    rd_check("run2_done_cleared", 4'd15, 32'd0);
    tick();
    rd_check("run2_precapture_read", 4'd15, 32'd0);
    check("run2_start_low", {127'd0, AES_START}, 128'd0);
    rd_check("run2_done_flag", 4'd15, 32'd1);
    rd_check("run2_cycles", 4'd12, 32'd6);
    rd_check("run2_key_frozen", 4'd0, 32'h00010203);
    bus_write(4'd14, 32'd0, 4'hf);

    // Byte-enable write in IDLE and write to a read-only word
    bus_write(4'd0, 32'haabbccdd, 4'b0010);
    rd_check("byte_en_lane1", 4'd0, 32'h0001cc03);
    check("byte_en_key", AES_KEY[127:96], {96'd0, 32'h0001cc03});
    bus_write(4'd8, 32'h12345678, 4'hf);
    rd_check("ro_write_ignored", 4'd8, 32'hece298dc);

    // Reset two cycles into a run; the stub's late DONE must not be captured
    bus_write(4'd14, 32'd1, 4'hf);
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("reset_mid_run_start", {127'd0, AES_START}, 128'd0);
    rd_check("reset_mid_run_status", 4'd13, 32'd0);
    for (int i = 0; i < 16; i++) rd_check("reset_mid_run_read", 4'(i), 32'd0);
    rd_check("late_done_no_capture", 4'd8, 32'd0);
    rd_check("late_done_flag", 4'd15, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
